// File: rtl/bsg_mcl_pkg.sv
// Shared widths for the manycore endpoint-to-fifo bridge host adapters.
package bsg_mcl_pkg;

  localparam int bsg_mcl_fifo_width_gp = 128;
  localparam int bsg_mcl_word_width_gp = 32;

  // Word-select index width, kept at least 1 bit for single-word packets.
  function automatic int bsg_mcl_idx_width(input int words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

endpackage

// File: rtl/bsg_mcl_packet_serializer.sv
// Receive half: latches one packet and hands it out one word at a time,
// word 0 (least-significant slice) first.
module bsg_mcl_packet_serializer
  import bsg_mcl_pkg::*;
#(
  parameter int word_width_p = bsg_mcl_word_width_gp,
  parameter int fifo_width_p = bsg_mcl_fifo_width_gp,
  localparam int lp_words    = fifo_width_p / word_width_p,
  localparam int lp_cnt_w    = $clog2(lp_words + 1)
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  logic                    pkt_v_i,
  input  logic [fifo_width_p-1:0] pkt_i,
  output logic                    pkt_rdy_o,
  output logic                    word_v_o,
  output logic [word_width_p-1:0] word_o,
  input  logic                    word_yumi_i,
  output logic [lp_cnt_w-1:0]     words_o
);

  localparam int lp_idx_w = bsg_mcl_idx_width(lp_words);
  localparam logic [lp_cnt_w-1:0] lp_words_c = lp_cnt_w'(lp_words);

  logic [lp_cnt_w-1:0]                      words_q, words_d;
  logic [lp_words-1:0][word_width_p-1:0]    pkt_q, pkt_d;
  logic [lp_cnt_w-1:0]                      word_sel;

  assign pkt_rdy_o = (words_q == '0);
  assign word_v_o  = (words_q != '0);
  assign words_o   = words_q;
  assign word_sel  = lp_words_c - words_q;
  assign word_o    = pkt_q[lp_idx_w'(word_sel)];

  always_comb begin
    words_d = words_q;
    pkt_d   = pkt_q;
    if (pkt_v_i && pkt_rdy_o) begin
      pkt_d   = pkt_i;
      words_d = lp_words_c;
    end else if (word_yumi_i && word_v_o) begin
      words_d = words_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) words_q <= '0;
    else            words_q <= words_d;
  end

  always_ff @(posedge clk_i) begin
    pkt_q <= pkt_d;
  end

  yumi_only_when_valid: assert property (
    @(posedge clk_i) disable iff (!reset_n_i) word_yumi_i |-> word_v_o
  );

endmodule

// File: rtl/bsg_mcl_fifo_word_packer.sv
// Host-side width adapter for one bridge fifo lane pair: packs host words
// into packets (tx) and serializes packets into host words (rx).
// Optional BSG_MCL_PACKER_STAGED_EN lets assembly continue while a packet waits.
module bsg_mcl_fifo_word_packer
  import bsg_mcl_pkg::*;
#(
  parameter int word_width_p = bsg_mcl_word_width_gp,
  parameter int fifo_width_p = bsg_mcl_fifo_width_gp,
  localparam int lp_words    = fifo_width_p / word_width_p,
  localparam int lp_cnt_w    = $clog2(lp_words + 1)
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  logic                    tx_word_v_i,
  input  logic [word_width_p-1:0] tx_word_i,
  output logic                    tx_word_rdy_o,
  output logic                    tx_pkt_v_o,
  output logic [fifo_width_p-1:0] tx_pkt_o,
  input  logic                    tx_pkt_rdy_i,
  input  logic                    rx_pkt_v_i,
  input  logic [fifo_width_p-1:0] rx_pkt_i,
  output logic                    rx_pkt_rdy_o,
  output logic                    rx_word_v_o,
  output logic [word_width_p-1:0] rx_word_o,
  input  logic                    rx_word_yumi_i,
  output logic [lp_cnt_w-1:0]     tx_words_o,
  output logic [lp_cnt_w-1:0]     rx_words_o
);

  localparam int lp_idx_w = bsg_mcl_idx_width(lp_words);
  localparam logic [lp_cnt_w-1:0] lp_last_c = lp_cnt_w'(lp_words - 1);

  logic [lp_cnt_w-1:0]                   tx_words_q, tx_words_d;
  logic                                  tx_pkt_v_q, tx_pkt_v_d;
  logic [lp_words-1:0][word_width_p-1:0] asm_q, asm_d;
  logic [lp_words-1:0][word_width_p-1:0] pkt_q, pkt_d;
  logic                                  tx_word_xfer, tx_pkt_xfer;

`ifdef BSG_MCL_PACKER_STAGED_EN
  // The packet register acts as the second buffer; only the word that would
  // complete a packet must wait for the pending one to drain.
  assign tx_word_rdy_o = ~(tx_pkt_v_q & (tx_words_q == lp_last_c)) | tx_pkt_rdy_i;
`else
  assign tx_word_rdy_o = ~tx_pkt_v_q;
`endif

  assign tx_word_xfer = tx_word_v_i & tx_word_rdy_o;
  assign tx_pkt_xfer  = tx_pkt_v_q & tx_pkt_rdy_i;
  assign tx_pkt_v_o   = tx_pkt_v_q;
  assign tx_pkt_o     = pkt_q;
  assign tx_words_o   = tx_words_q;

  always_comb begin
    tx_words_d = tx_words_q;
    tx_pkt_v_d = tx_pkt_v_q;
    asm_d      = asm_q;
    pkt_d      = pkt_q;
    if (tx_pkt_xfer) tx_pkt_v_d = 1'b0;
    if (tx_word_xfer) begin
      asm_d[lp_idx_w'(tx_words_q)] = tx_word_i;
      if (tx_words_q == lp_last_c) begin
        pkt_d      = asm_d;
        tx_pkt_v_d = 1'b1;
        tx_words_d = '0;
      end else begin
        tx_words_d = tx_words_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      tx_words_q <= '0;
      tx_pkt_v_q <= 1'b0;
    end else begin
      tx_words_q <= tx_words_d;
      tx_pkt_v_q <= tx_pkt_v_d;
    end
  end

  always_ff @(posedge clk_i) begin
    asm_q <= asm_d;
    pkt_q <= pkt_d;
  end

  bsg_mcl_packet_serializer #(
    .word_width_p(word_width_p),
    .fifo_width_p(fifo_width_p)
  ) u_rx (
    .clk_i      (clk_i),
    .reset_n_i  (reset_n_i),
    .pkt_v_i    (rx_pkt_v_i),
    .pkt_i      (rx_pkt_i),
    .pkt_rdy_o  (rx_pkt_rdy_o),
    .word_v_o   (rx_word_v_o),
    .word_o     (rx_word_o),
    .word_yumi_i(rx_word_yumi_i),
    .words_o    (rx_words_o)
  );

endmodule

// File: tb/tb_bsg_mcl_fifo_word_packer.sv
// Bench for bsg_mcl_fifo_word_packer: queue-based model checked every cycle
// plus directed scenarios with literal expectations.
module tb_bsg_mcl_fifo_word_packer;

  localparam int W  = 32;
  localparam int F  = 128;
  localparam int N  = F / W;
  localparam int CW = $clog2(N + 1);
`ifdef BSG_MCL_PACKER_STAGED_EN
  localparam int HELD_ACCEPT = 2 * N - 1;
`else
  localparam int HELD_ACCEPT = N;
`endif

  logic          clk = 1'b0;
  logic          reset_n_i = 1'b0;
  logic          tx_word_v_i = 1'b0;
  logic [W-1:0]  tx_word_i = '0;
  logic          tx_word_rdy_o;
  logic          tx_pkt_v_o;
  logic [F-1:0]  tx_pkt_o;
  logic          tx_pkt_rdy_i = 1'b0;
  logic          rx_pkt_v_i = 1'b0;
  logic [F-1:0]  rx_pkt_i = '0;
  logic          rx_pkt_rdy_o;
  logic          rx_word_v_o;
  logic [W-1:0]  rx_word_o;
  logic          rx_word_yumi_i = 1'b0;
  logic [CW-1:0] tx_words_o;
  logic [CW-1:0] rx_words_o;

  bsg_mcl_fifo_word_packer #(
    .word_width_p(W),
    .fifo_width_p(F)
  ) dut (
    .clk_i         (clk),
    .reset_n_i     (reset_n_i),
    .tx_word_v_i   (tx_word_v_i),
    .tx_word_i     (tx_word_i),
    .tx_word_rdy_o (tx_word_rdy_o),
    .tx_pkt_v_o    (tx_pkt_v_o),
    .tx_pkt_o      (tx_pkt_o),
    .tx_pkt_rdy_i  (tx_pkt_rdy_i),
    .rx_pkt_v_i    (rx_pkt_v_i),
    .rx_pkt_i      (rx_pkt_i),
    .rx_pkt_rdy_o  (rx_pkt_rdy_o),
    .rx_word_v_o   (rx_word_v_o),
    .rx_word_o     (rx_word_o),
    .rx_word_yumi_i(rx_word_yumi_i),
    .tx_words_o    (tx_words_o),
    .rx_words_o    (rx_words_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit mv    = 1'b0;

  logic [W-1:0] m_part[$];
  logic [F-1:0] m_pkts[$];
  logic [W-1:0] m_rx[$];

  task automatic chk(input string nm, input logic [F-1:0] act, input logic [F-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic bit m_tx_rdy();
`ifdef BSG_MCL_PACKER_STAGED_EN
    return !(m_pkts.size() != 0 && m_part.size() == N - 1) || tx_pkt_rdy_i;
`else
    return m_pkts.size() == 0;
`endif
  endfunction

  // Model: outputs after an edge are a function of the words/packets accepted so far.
  always @(negedge clk) begin
    bit txw, rxa;
    logic [F-1:0] p;
    if (mv) begin
      chk("m_tx_words", F'(tx_words_o), F'(m_part.size()));
      chk("m_tx_pkt_v", F'(tx_pkt_v_o), F'(m_pkts.size() != 0));
      chk("m_tx_rdy", F'(tx_word_rdy_o), F'(m_tx_rdy()));
      if (m_pkts.size() != 0) chk("m_tx_pkt", tx_pkt_o, m_pkts[0]);
      chk("m_rx_words", F'(rx_words_o), F'(m_rx.size()));
      chk("m_rx_v", F'(rx_word_v_o), F'(m_rx.size() != 0));
      chk("m_rx_rdy", F'(rx_pkt_rdy_o), F'(m_rx.size() == 0));
      if (m_rx.size() != 0) chk("m_rx_word", F'(rx_word_o), F'(m_rx[0]));
    end
    if (!reset_n_i) begin
      m_part.delete();
      m_pkts.delete();
      m_rx.delete();
      mv = 1'b1;
    end else if (mv) begin
      txw = tx_word_v_i && m_tx_rdy();
      if (m_pkts.size() != 0 && tx_pkt_rdy_i) void'(m_pkts.pop_front());
      if (txw) begin
        m_part.push_back(tx_word_i);
        if (m_part.size() == N) begin
          p = '0;
          for (int i = 0; i < N; i++) p[i*W +: W] = m_part[i];
          m_pkts.push_back(p);
          m_part.delete();
        end
      end
      rxa = rx_pkt_v_i && (m_rx.size() == 0);
      if (rx_word_yumi_i && m_rx.size() != 0) void'(m_rx.pop_front());
      if (rxa) for (int i = 0; i < N; i++) m_rx.push_back(rx_pkt_i[i*W +: W]);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] wd[8];
    logic [W-1:0] t1w[4];
    logic [W-1:0] p1w[4];
    logic [W-1:0] p2w[4];
    logic [F-1:0] e0, e1;
    int k, got;

    t1w = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
    p1w = '{32'h0000AAAA, 32'h0000BBBB, 32'h0000CCCC, 32'h0000DDDD};
    p2w = '{32'hCAFEF00D, 32'hDEADBEEF, 32'h01234567, 32'h89ABCDEF};

    reset_n_i = 1'b0;
    step(); step();
    reset_n_i = 1'b1;
    chk("rst_tx_words", F'(tx_words_o), 0);
    chk("rst_tx_rdy", F'(tx_word_rdy_o), 1);
    chk("rst_rx_rdy", F'(rx_pkt_rdy_o), 1);
    chk("rst_rx_v", F'(rx_word_v_o), 0);
    chk("rst_tx_pkt_v", F'(tx_pkt_v_o), 0);

    // Four words assembled into one packet, bridge ready.
    tx_pkt_rdy_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("t1_words", F'(tx_words_o), F'(i));
      tx_word_v_i = 1'b1;
      tx_word_i   = t1w[i];
      step();
    end
    tx_word_v_i = 1'b0;
    chk("t1_words_wrap", F'(tx_words_o), 0);
    chk("t1_pkt_v", F'(tx_pkt_v_o), 1);
    chk("t1_pkt", tx_pkt_o, 128'h44444444_33333333_22222222_11111111);
    step();
    chk("t1_pkt_v_clear", F'(tx_pkt_v_o), 0);

    // Back-pressure on the bridge with eight words offered.
    for (int i = 0; i < 8; i++) wd[i] = 32'hA0000000 + 32'(i * 32'h01010101);
    e0 = {wd[3], wd[2], wd[1], wd[0]};
    e1 = {wd[7], wd[6], wd[5], wd[4]};
    tx_pkt_rdy_i = 1'b0;
    k = 0;
    for (int c = 0; c < 12; c++) begin
      tx_word_v_i = (k < 8);
      tx_word_i   = wd[k & 7];
      #1;
      if (tx_word_rdy_o && k < 8) k++;
      step();
    end
    chk("t2_accepted_held", F'(k), F'(HELD_ACCEPT));
    chk("t2_rdy_low", F'(tx_word_rdy_o), 0);
    tx_pkt_rdy_i = 1'b1;
    got = 0;
    for (int c = 0; c < 20; c++) begin
      tx_word_v_i = (k < 8);
      tx_word_i   = wd[k & 7];
      #1;
      if (tx_word_rdy_o && k < 8) k++;
      if (tx_pkt_v_o) begin
        chk("t2_pkt_order", tx_pkt_o, (got == 0) ? e0 : e1);
        got++;
      end
      step();
    end
    tx_word_v_i = 1'b0;
    chk("t2_all_words", F'(k), 8);
    chk("t2_pkts_delivered", F'(got), 2);

    // Receive one packet with yumi following valid.
    rx_pkt_v_i = 1'b1;
    rx_pkt_i   = 128'h0000DDDD_0000CCCC_0000BBBB_0000AAAA;
    step();
    rx_pkt_v_i = 1'b0;
    for (int j = 0; j < 4; j++) begin
      chk("t3_rx_v", F'(rx_word_v_o), 1);
      chk("t3_rx_word", F'(rx_word_o), F'(p1w[j]));
      rx_word_yumi_i = 1'b1;
      step();
    end
    rx_word_yumi_i = 1'b0;
    chk("t3_rearm", F'(rx_pkt_rdy_o), 1);
    chk("t3_rx_v_low", F'(rx_word_v_o), 0);

    // Second packet held valid while the first drains.
    rx_pkt_v_i = 1'b1;
    rx_pkt_i   = 128'h0000DDDD_0000CCCC_0000BBBB_0000AAAA;
    step();
    rx_pkt_i = 128'h89ABCDEF_01234567_DEADBEEF_CAFEF00D;
    for (int j = 0; j < 4; j++) begin
      chk("t4_rdy_low", F'(rx_pkt_rdy_o), 0);
      chk("t4_first_word", F'(rx_word_o), F'(p1w[j]));
      rx_word_yumi_i = 1'b1;
      step();
    end
    rx_word_yumi_i = 1'b0;
    chk("t4_rdy_back", F'(rx_pkt_rdy_o), 1);
    step();
    rx_pkt_v_i = 1'b0;
    chk("t4_second_loaded", F'(rx_words_o), 4);
    for (int j = 0; j < 4; j++) begin
      chk("t4_second_word", F'(rx_word_o), F'(p2w[j]));
      rx_word_yumi_i = 1'b1;
      step();
    end
    rx_word_yumi_i = 1'b0;

    // Reset mid-packet on both halves.
    tx_word_v_i = 1'b1;
    tx_word_i = 32'hBAD00001; step();
    tx_word_i = 32'hBAD00002; step();
    tx_word_v_i = 1'b0;
    rx_pkt_v_i = 1'b1;
    rx_pkt_i = 128'h0000DDDD_0000CCCC_0000BBBB_0000AAAA;
    step();
    rx_pkt_v_i = 1'b0;
    rx_word_yumi_i = 1'b1; step();
    rx_word_yumi_i = 1'b0;
    chk("t5_pre_tx_words", F'(tx_words_o), 2);
    chk("t5_pre_rx_words", F'(rx_words_o), 3);
    reset_n_i = 1'b0; step();
    reset_n_i = 1'b1;
    chk("t5_tx_words", F'(tx_words_o), 0);
    chk("t5_rx_words", F'(rx_words_o), 0);
    chk("t5_tx_pkt_v", F'(tx_pkt_v_o), 0);
    chk("t5_rx_v", F'(rx_word_v_o), 0);
    for (int i = 0; i < 4; i++) begin
      tx_word_v_i = 1'b1;
      tx_word_i   = 32'h00000005 + 32'(i);
      step();
    end
    tx_word_v_i = 1'b0;
    chk("t5_clean_pkt_v", F'(tx_pkt_v_o), 1);
    chk("t5_clean_pkt", tx_pkt_o, 128'h00000008_00000007_00000006_00000005);
    step();

    // Random traffic and back-pressure on both halves.
    for (int c = 0; c < 10000; c++) begin
      tx_word_v_i    = ($urandom_range(3) != 0);
      tx_word_i      = $urandom;
      tx_pkt_rdy_i   = ($urandom_range(2) != 0);
      rx_pkt_v_i     = $urandom_range(1);
      rx_pkt_i       = {$urandom, $urandom, $urandom, $urandom};
      rx_word_yumi_i = ($urandom_range(3) != 0) && (m_rx.size() != 0);
      step();
    end
    tx_word_v_i  = 1'b0;
    rx_pkt_v_i   = 1'b0;
    tx_pkt_rdy_i = 1'b1;
    for (int c = 0; c < 20; c++) begin
      rx_word_yumi_i = (m_rx.size() != 0);
      step();
    end
    rx_word_yumi_i = 1'b0;
    chk("drain_tx_pkt_v", F'(tx_pkt_v_o), 0);
    chk("drain_rx_words", F'(rx_words_o), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
